video_timing_tracker: RTL

- Registered one-cycle pipeline stage between the HDMI decoder outputs and the pixel-manipulation stage.
- Passes RGB, DE, HSYNC and VSYNC through unchanged, delayed by exactly one clock.
- Adds per-pixel coordinates, a start-of-frame pulse, a frame counter and measured active resolution.
- Replaces ad-hoc hsync-reset pixel counters in downstream pattern and filter stages.

---
 rtl/video_timing_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 24 ++
 rtl/video_timing_tracker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared types and constants for the video timing tracker
package video_timing_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        MEASURE    = 2'd1,
        LOCKED     = 2'd2
    } vt_state_t;

    localparam int X_WIDTH_DEF  = 12;
    localparam int Y_WIDTH_DEF  = 11;
    localparam int FC_WIDTH_DEF = 8;
    localparam int RGB_W        = 24;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - registers a sync/enable level and flags its leading edge
module sync_edge_detect #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic p_clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic lead
);

    logic sig_prev;

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig_in;
        end
    end

    // Combinational against the registered level so the pulse lines up with the sampling edge.
    assign lead = ACTIVE_HIGH ? (sig_in & ~sig_prev) : (~sig_in & sig_prev);

endmodule

// File: rtl/video_timing_tracker.sv
// rtl/video_timing_tracker.sv - one-cycle video stage adding coordinates, SOF and resolution lock
module video_timing_tracker
    import video_timing_pkg::*;
#(
    parameter int X_WIDTH           = X_WIDTH_DEF,
    parameter int Y_WIDTH           = Y_WIDTH_DEF,
    parameter int FC_WIDTH          = FC_WIDTH_DEF,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic                p_clock,
    input  logic                reset_n,
    input  logic                de_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [RGB_W-1:0]    rgb_in,
    output logic                de_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic [RGB_W-1:0]    rgb_out,
    output logic [X_WIDTH-1:0]  x_pos,
    output logic [Y_WIDTH-1:0]  y_pos,
    output logic                sof,
    output logic [FC_WIDTH-1:0] frame_count,
    output logic [X_WIDTH-1:0]  active_width,
    output logic [Y_WIDTH-1:0]  active_height,
    output logic                timing_valid
);

    localparam logic [X_WIDTH-1:0] X_MAX = '1;
    localparam logic [Y_WIDTH-1:0] Y_MAX = '1;
    localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);

    logic               vs_lead;
    logic               de_fall;
    logic [X_WIDTH-1:0] x_cnt;
    logic [X_WIDTH-1:0] x_inc;
    logic [Y_WIDTH-1:0] line_cnt;
    logic [Y_WIDTH-1:0] line_inc;
    logic [X_WIDTH-1:0] ref_w;
    logic               width_err;
    logic               sof_pending;
    logic               seen_vs;
    vt_state_t          state;
    vt_state_t          state_nx;
    logic               lock_load;
    logic               valid_nx;
    logic               size_match;

    sync_edge_detect #(.ACTIVE_HIGH(VSYNC_ACTIVE_HIGH)) u_vs_edge (
        .p_clock (p_clock),
        .reset_n (reset_n),
        .sig_in  (vsync_in),
        .lead    (vs_lead)
    );

    sync_edge_detect #(.ACTIVE_HIGH(1'b0)) u_de_edge (
        .p_clock (p_clock),
        .reset_n (reset_n),
        .sig_in  (de_in),
        .lead    (de_fall)
    );

    assign x_inc    = (x_cnt == X_MAX) ? x_cnt : x_cnt + 1'b1;
    assign line_inc = (line_cnt == Y_MAX) ? line_cnt : line_cnt + 1'b1;

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            rgb_out   <= '0;
        end else begin
            de_out    <= de_in;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            rgb_out   <= rgb_in;
        end
    end

    // A vsync lead takes priority over everything: a coincident pixel becomes pixel 0 of the new frame.
    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt       <= '0;
            line_cnt    <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            ref_w       <= '0;
            width_err   <= 1'b0;
            sof         <= 1'b0;
            sof_pending <= 1'b0;
            seen_vs     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (vs_lead) begin
                x_cnt     <= de_in ? X_ONE : '0;
                line_cnt  <= '0;
                y_pos     <= '0;
                ref_w     <= '0;
                width_err <= 1'b0;
            end else if (de_in) begin
                x_cnt <= x_inc;
                y_pos <= line_cnt;
            end else if (de_fall) begin
                x_cnt    <= '0;
                line_cnt <= line_inc;
                if (line_cnt == '0) begin
                    ref_w <= x_cnt;
                end else if (x_cnt != ref_w) begin
                    width_err <= 1'b1;
                end
            end

            x_pos <= (de_in && !vs_lead) ? x_cnt : '0;
            sof   <= de_in && (vs_lead || sof_pending);

            if (vs_lead) begin
                sof_pending <= !de_in;
            end else if (de_in) begin
                sof_pending <= 1'b0;
            end

            if (vs_lead) begin
                seen_vs <= 1'b1;
                if (seen_vs) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    assign size_match = (ref_w == active_width) && (line_cnt == active_height) && !width_err;

    always_comb begin
        state_nx  = state;
        lock_load = 1'b0;
        valid_nx  = timing_valid;
        if (vs_lead) begin
            case (state)
                WAIT_VSYNC: state_nx = MEASURE;
                MEASURE: begin
                    if ((line_cnt != '0) && (ref_w != '0) && !width_err) begin
                        state_nx  = LOCKED;
                        lock_load = 1'b1;
                        valid_nx  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!size_match) begin
                        state_nx = MEASURE;
                        valid_nx = 1'b0;
                    end
                end
                default: begin
                    state_nx = WAIT_VSYNC;
                    valid_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_VSYNC;
            timing_valid  <= 1'b0;
            active_width  <= '0;
            active_height <= '0;
        end else begin
            state        <= state_nx;
            timing_valid <= valid_nx;
            if (lock_load) begin
                active_width  <= ref_w;
                active_height <= line_cnt;
            end
        end
    end

endmodule
